// File: rtl/sy_upcnt_ctrl.sv
// sy_upcnt_ctrl: sequences one up-counter through clear, prescaled counting and terminal detect.
module sy_upcnt_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] term,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [7:0]       periods
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
    state_t state;
    logic [WIDTH-1:0] term_l;
    logic [PRE_W-1:0] pre_l, pre_cnt;
    logic per_l, tick, last;
    // >= rather than == so an out-of-range counter value still terminates the period
    always_comb begin
        tick = state == RUN && !pause && pre_cnt == pre_l;
        last = tick && cnt_q >= term_l;
        cnt_en = tick && !last && !stop;
        cnt_clr = !stop && (state == CLEAR || (last && per_l));
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            term_l  <= '0;
            pre_l   <= '0;
            per_l   <= 1'b0;
            pre_cnt <= '0;
            done    <= 1'b0;
            periods <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !stop) begin
                    term_l  <= term;
                    pre_l   <= prescale;
                    per_l   <= periodic;
                    periods <= '0;
                    state   <= CLEAR;
                end
                CLEAR: begin
                    pre_cnt <= '0;
                    state   <= stop ? IDLE : RUN;
                end
                RUN: if (stop) state <= IDLE;
                else begin
                    if (!pause) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                    if (last) begin
                        done <= 1'b1;
                        if (!per_l) state <= IDLE;
                        else if (periods != 8'hFF) periods <= periods + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
